sobel_edge_detect: RTL and testbench

// - Streaming Sobel edge detector for one raster-order image frame of WIDTH*HEIGHT pixels.
// - Accepts 24-bit colour pixels through an input FIFO and converts each to 8-bit grayscale.
// - Applies a 3x3 Sobel operator and emits one 8-bit edge magnitude per pixel through an output FIFO.
// - Sits between a pixel source (e.g. BMP reader) and a pixel sink; both sides use FIFO handshakes.

---
 rtl/sobel_edge_detect.sv | 188 ++++++++++++++++++
 tb/tb_sobel_edge_detect.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_detect.sv
// Streaming 3x3 Sobel edge detector: RGB pixels in through a FWFT FIFO, 8-bit edge magnitudes out through a FWFT FIFO.
// A stalled (full) output FIFO freezes the whole pipeline; border pixels and the end-of-frame flush emit 0.

module sobel_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [DW-1:0] din_i,
  output logic          full_o,
  input  logic          rd_en_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;
  // Forced to 0 when empty so the head reads 0 during and right after reset.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end
endmodule

module sobel_edge_detect #(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic        input_full,
  input  logic        input_wr_en,
  input  logic [23:0] input_din,
  output logic        out_empty,
  input  logic        out_rd_en,
  output logic [7:0]  out_dout
);
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int NSTEP  = NPIX + WIDTH + 1;
  localparam int SW     = $clog2(NSTEP + 1);
  localparam int LB_LEN = 2 * WIDTH + 3;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int RW     = $clog2(HEIGHT + 1);

  logic        in_empty, in_rd;
  logic [23:0] in_dout;
  logic        out_full, out_push;
  logic [7:0]  out_din;

  sobel_fifo #(.DW(24), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en_i (input_wr_en),
    .din_i   (input_din),
    .full_o  (input_full),
    .rd_en_i (in_rd),
    .dout_o  (in_dout),
    .empty_o (in_empty)
  );

  sobel_fifo #(.DW(8), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en_i (out_push),
    .din_i   (out_din),
    .full_o  (out_full),
    .rd_en_i (out_rd_en),
    .dout_o  (out_dout),
    .empty_o (out_empty)
  );

  // step_q indexes the element being shifted into the line buffer: pixels 0..NPIX-1, then WIDTH+1 flush slots.
  logic [SW-1:0] step_q, step_d;
  logic          vld_q, vld_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    lb_q [LB_LEN];
  logic          flushing, step;
  logic [9:0]    rgb_sum;
  logic [7:0]    gray_new;

  assign flushing = (step_q >= SW'(NPIX));
  assign step     = !out_full && (flushing || !in_empty);
  assign in_rd    = step && !flushing;
  assign out_push = vld_q && !out_full;

  assign rgb_sum  = {2'b00, in_dout[7:0]} + {2'b00, in_dout[15:8]} + {2'b00, in_dout[23:16]};
  assign gray_new = flushing ? 8'd0 : 8'(rgb_sum / 10'd3);

  always_comb begin
    step_d = step_q;
    vld_d  = vld_q;
    col_d  = col_q;
    row_d  = row_q;
    if (step) begin
      step_d = (step_q == SW'(NSTEP - 1)) ? '0 : step_q + 1'b1;
      vld_d  = (step_q >= SW'(WIDTH + 1));
    end else if (out_push) begin
      vld_d = 1'b0;
    end
    if (out_push) begin
      if (col_q == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_q <= '0;
      vld_q  <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      for (int i = 0; i < LB_LEN; i++) lb_q[i] <= 8'd0;
    end else begin
      step_q <= step_d;
      vld_q  <= vld_d;
      col_q  <= col_d;
      row_q  <= row_d;
      if (step) begin
        lb_q[0] <= gray_new;
        for (int i = 1; i < LB_LEN; i++) lb_q[i] <= lb_q[i-1];
      end
    end
  end

  // win[r][c] is the 3x3 neighbourhood of the pixel at the output counters; lb_q[0] is the newest sample.
  logic signed [11:0] win [3][3];
  logic signed [11:0] gx, gy;
  logic [11:0]        ax, ay, abs_sum;
  logic [10:0]        half;
  logic [7:0]         mag;
  logic               border;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win[r][c] = signed'({4'b0000, lb_q[(2 - r) * WIDTH + (2 - c)]});
      end
    end
  end

  assign gx = win[0][2] + win[1][2] + win[1][2] + win[2][2]
            - win[0][0] - win[1][0] - win[1][0] - win[2][0];
  assign gy = win[2][0] + win[2][1] + win[2][1] + win[2][2]
            - win[0][0] - win[0][1] - win[0][1] - win[0][2];
  assign ax      = gx[11] ? 12'(-gx) : 12'(gx);
  assign ay      = gy[11] ? 12'(-gy) : 12'(gy);
  assign abs_sum = ax + ay;
  assign half    = abs_sum[11:1];
  assign mag     = (|half[10:8]) ? 8'hFF : half[7:0];

  assign border  = (row_q == '0) || (row_q == RW'(HEIGHT - 1)) ||
                   (col_q == '0) || (col_q == CW'(WIDTH - 1));
  assign out_din = border ? 8'd0 : mag;
endmodule

// File: tb/tb_sobel_edge_detect.sv
// Self-checking bench for sobel_edge_detect on a 4x4 frame with shallow FIFOs to exercise backpressure.
module tb_sobel_edge_detect;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        input_full;
  logic        input_wr_en = 1'b0;
  logic [23:0] input_din = '0;
  logic        out_empty;
  logic        out_rd_en = 1'b0;
  logic [7:0]  out_dout;

  int checks = 0;
  int errors = 0;

  logic [23:0] pix_q [$];
  logic [7:0]  exp_q [$];
  logic [23:0] frame [N];
  string       cur_name;

  typedef struct packed {
    logic [N-1:0][23:0] px;
    logic [N-1:0][7:0]  ex;
  } vec_t;
  vec_t  tbl [4];
  string tname [4];

  sobel_edge_detect #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .input_full  (input_full),
    .input_wr_en (input_wr_en),
    .input_din   (input_din),
    .out_empty   (out_empty),
    .out_rd_en   (out_rd_en),
    .out_dout    (out_dout)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Reference: grayscale then direct 3x3 convolution over a 2-D array.
  task automatic model_frame();
    int g [H][W];
    int gx, gy, m;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        g[r][c] = (int'(frame[r*W+c][7:0]) + int'(frame[r*W+c][15:8]) + int'(frame[r*W+c][23:16])) / 3;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        pix_q.push_back(frame[r*W+c]);
        if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
          exp_q.push_back(8'd0);
        end else begin
          gx = 0;
          gy = 0;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              gx += dc * ((dr == 0) ? 2 : 1) * g[r+dr][c+dc];
              gy += dr * ((dc == 0) ? 2 : 1) * g[r+dr][c+dc];
            end
          end
          m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
          if (m > 255) m = 255;
          exp_q.push_back(8'(m));
        end
      end
    end
  endtask

  // Feeds pix_q and drains against exp_q, each side gated by a random percentage.
  task automatic run(input int wr_pct, input int rd_pct, input bit stop_when_full, input int budget);
    int cyc = 0;
    while ((pix_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clock);
      cyc++;
      input_wr_en = 1'b0;
      out_rd_en   = 1'b0;
      if (stop_when_full && input_full) break;
      if (pix_q.size() > 0 && !input_full && $urandom_range(99) < wr_pct) begin
        input_wr_en = 1'b1;
        input_din   = pix_q.pop_front();
      end
      if (!out_empty && $urandom_range(99) < rd_pct) begin
        if (exp_q.size() == 0) check({cur_name, " extra_output"}, 32'(out_dout), 32'hDEAD);
        else check({cur_name, " out"}, 32'(out_dout), 32'(exp_q.pop_front()));
        out_rd_en = 1'b1;
      end
    end
    @(negedge clock);
    input_wr_en = 1'b0;
    out_rd_en   = 1'b0;
    if (stop_when_full) check({cur_name, " reached_full"}, 32'(input_full), 32'd1);
    else if (exp_q.size() > 0) check({cur_name, " timeout_remaining"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic expect_idle(input string nm);
    repeat (20) @(negedge clock);
    check({nm, " no_extra_output"}, 32'(out_empty), 32'd1);
  endtask

  initial begin
    tname[0] = "uniform";
    tname[1] = "vstep";
    tname[2] = "gray_col3";
    tname[3] = "hstep";
    for (int i = 0; i < N; i++) begin
      tbl[0].px[i] = 24'h808080;
      tbl[1].px[i] = (i % W >= 2) ? 24'hFFFFFF : 24'h000000;
      tbl[2].px[i] = (i % W == 3) ? 24'h0A1420 : 24'h000000;
      tbl[3].px[i] = (i / W >= 2) ? 24'hFFFFFF : 24'h000000;
      for (int v = 0; v < 4; v++) tbl[v].ex[i] = 8'h00;
    end
    tbl[1].ex[5]  = 8'hFF; tbl[1].ex[6]  = 8'hFF; tbl[1].ex[9]  = 8'hFF; tbl[1].ex[10] = 8'hFF;
    tbl[2].ex[6]  = 8'h28; tbl[2].ex[10] = 8'h28;
    tbl[3].ex[5]  = 8'hFF; tbl[3].ex[6]  = 8'hFF; tbl[3].ex[9]  = 8'hFF; tbl[3].ex[10] = 8'hFF;

    repeat (3) @(negedge clock);
    check("reset input_full", 32'(input_full), 32'd0);
    check("reset out_empty", 32'(out_empty), 32'd1);
    check("reset out_dout", 32'(out_dout), 32'd0);
    reset = 1'b1;

    for (int v = 0; v < 4; v++) begin
      cur_name = tname[v];
      for (int i = 0; i < N; i++) begin
        pix_q.push_back(tbl[v].px[i]);
        exp_q.push_back(tbl[v].ex[i]);
      end
      run(100, 100, 1'b0, 2000);
      expect_idle(tname[v]);
    end

    for (int f = 0; f < 6; f++) begin
      cur_name = "random";
      for (int i = 0; i < N; i++) frame[i] = 24'($urandom);
      model_frame();
      run($urandom_range(30, 100), $urandom_range(20, 100), 1'b0, 3000);
    end
    expect_idle("random");

    cur_name = "back_to_back";
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) frame[i] = 24'($urandom);
      model_frame();
    end
    run(100, 100, 1'b0, 2000);
    expect_idle("back_to_back");

    cur_name = "backpressure";
    for (int i = 0; i < N; i++) frame[i] = 24'($urandom);
    model_frame();
    run(100, 0, 1'b1, 500);
    check("backpressure out_empty", 32'(out_empty), 32'd0);
    check("backpressure pending_input", 32'(pix_q.size() > 0), 32'd1);
    @(negedge clock);
    input_wr_en = 1'b1;
    input_din   = 24'h5A5A5A;
    @(negedge clock);
    input_wr_en = 1'b0;
    check("backpressure still_full", 32'(input_full), 32'd1);
    run(100, 100, 1'b0, 2000);
    expect_idle("backpressure");

    cur_name = "reset_mid";
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      input_wr_en = 1'b1;
      input_din   = 24'($urandom);
    end
    @(negedge clock);
    input_wr_en = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_mid input_full", 32'(input_full), 32'd0);
    check("reset_mid out_empty", 32'(out_empty), 32'd1);
    check("reset_mid out_dout", 32'(out_dout), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < N; i++) frame[i] = 24'h808080;
    model_frame();
    run(100, 100, 1'b0, 2000);
    expect_idle("reset_mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
